dual_gate_arbiter: RTL and testbench

//  Clocked front end that shares one transition-signalled dual-rail gate (e.g. dual_and) among N_REQ requesters.

---
 rtl/dual_gate_arbiter_if.sv | 22 ++
 rtl/dual_gate_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dual_gate_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_gate_arbiter_if.sv
// Requester-side handshake bundle for dual_gate_arbiter: operand requests in, pulsed responses out.
interface dual_gate_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_x;
  logic [N_REQ-1:0] req_y;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ-1:0] resp_valid;
  logic             resp_data;
  logic             resp_error;

  modport master (
    output req_valid, req_x, req_y,
    input  req_ready, resp_valid, resp_data, resp_error
  );

  modport slave (
    input  req_valid, req_x, req_y,
    output req_ready, resp_valid, resp_data, resp_error
  );
endinterface

// File: rtl/dual_gate_arbiter.sv
// Round-robin front end sharing one transition-signalled dual-rail gate among N_REQ requesters;
// sequences gate reset and flags double-toggle or timeout faults.
module dual_gate_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clock,
  input  logic                      reset_n,
  dual_gate_arbiter_if.slave        req_if,
  output logic [1:0]                gate_x,
  output logic [1:0]                gate_y,
  output logic                      gate_reset,
  input  logic [1:0]                gate_result,
  output logic                      busy,
  output logic                      fault_sticky
);
  localparam int unsigned InitCycles = RESET_CYCLES + SYNC_STAGES;
  localparam int unsigned CntMax     = (TIMEOUT_CYCLES > InitCycles) ? TIMEOUT_CYCLES : InitCycles;
  localparam int unsigned CntW       = $clog2(CntMax + 1);
  localparam int unsigned IdxW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StInit, StIdle, StWait, StFault} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   rr_q, rr_d, gnt_q, gnt_d;
  logic [1:0]        gate_x_q, gate_x_d, gate_y_q, gate_y_d;
  logic              gate_reset_q, gate_reset_d;
  logic [1:0]        prev_q, prev_d;
  logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic              resp_data_q, resp_data_d, resp_error_q, resp_error_d;
  logic              sticky_q, sticky_d;
  logic [1:0]        sync_q [SYNC_STAGES];
  logic [1:0]        synced, diff;
  logic [N_REQ-1:0]  grant;
  logic [IdxW-1:0]   grant_idx, rr_next;
  logic              found;

  assign synced = sync_q[SYNC_STAGES-1];
  assign diff   = synced ^ prev_q;

  // First valid requester at or after the round-robin pointer, wrapping upward.
  always_comb begin
    found     = 1'b0;
    grant_idx = rr_q;
    grant     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned cand;
      cand = (32'(rr_q) + k) % N_REQ;
      if (!found && req_if.req_valid[IdxW'(cand)]) begin
        found     = 1'b1;
        grant_idx = IdxW'(cand);
      end
    end
    if (found) grant[grant_idx] = 1'b1;
    rr_next = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IdxW'(1);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    gate_x_d     = gate_x_q;
    gate_y_d     = gate_y_q;
    gate_reset_d = 1'b0;
    prev_d       = prev_q;
    resp_valid_d = '0;
    resp_data_d  = 1'b0;
    resp_error_d = 1'b0;
    sticky_d     = sticky_q;
    req_if.req_ready = '0;
    unique case (state_q)
      StInit: begin
        if (cnt_q == CntW'(InitCycles - 1)) begin
          cnt_d   = '0;
          prev_d  = synced;
          state_d = StIdle;
        end else begin
          cnt_d        = cnt_q + CntW'(1);
          gate_reset_d = (32'(cnt_q) + 32'd1) < RESET_CYCLES;
        end
      end
      StIdle: begin
        req_if.req_ready = grant;
        if (|(req_if.req_valid & grant)) begin
          gnt_d = grant_idx;
          // One rail per input toggles: high rail encodes 1, low rail encodes 0.
          if (req_if.req_x[grant_idx]) gate_x_d[1] = ~gate_x_q[1];
          else                         gate_x_d[0] = ~gate_x_q[0];
          if (req_if.req_y[grant_idx]) gate_y_d[1] = ~gate_y_q[1];
          else                         gate_y_d[0] = ~gate_y_q[0];
          cnt_d   = '0;
          rr_d    = rr_next;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (diff == 2'b10 || diff == 2'b01) begin
          resp_valid_d[gnt_q] = 1'b1;
          resp_data_d         = diff[1];
          prev_d              = synced;
          state_d             = StIdle;
        end else if (diff == 2'b11 || cnt_d == CntW'(TIMEOUT_CYCLES)) begin
          resp_valid_d[gnt_q] = 1'b1;
          resp_error_d        = 1'b1;
          state_d             = StFault;
        end
      end
      StFault: begin
        sticky_d     = 1'b1;
        gate_reset_d = 1'b1;
        cnt_d        = '0;
        state_d      = StInit;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
    end else begin
      sync_q[0] <= gate_result;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StInit;
      cnt_q        <= '0;
      rr_q         <= '0;
      gnt_q        <= '0;
      gate_x_q     <= 2'b00;
      gate_y_q     <= 2'b00;
      gate_reset_q <= 1'b1;
      prev_q       <= 2'b00;
      resp_valid_q <= '0;
      resp_data_q  <= 1'b0;
      resp_error_q <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      gate_x_q     <= gate_x_d;
      gate_y_q     <= gate_y_d;
      gate_reset_q <= gate_reset_d;
      prev_q       <= prev_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      sticky_q     <= sticky_d;
    end
  end

  assign gate_x            = gate_x_q;
  assign gate_y            = gate_y_q;
  assign gate_reset        = gate_reset_q;
  assign busy              = (state_q != StIdle);
  assign fault_sticky      = sticky_q;
  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_data  = resp_data_q;
  assign req_if.resp_error = resp_error_q;
endmodule

// File: tb/tb_dual_gate_arbiter.sv
// Bench for dual_gate_arbiter: zero-delay dual_and gate model with silent/double-toggle faults,
// a transaction-timeline reference model checked every cycle, and directed literal checks.
module tb_dual_gate_arbiter;
  localparam int N       = 4;
  localparam int SYNC    = 2;
  localparam int RSTC    = 2;
  localparam int TIMEOUT = 64;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] gate_x, gate_y;
  logic       gate_reset, busy, fault_sticky;
  logic [1:0] gate_result = 2'b00;
  logic [1:0] g_ref_x = 2'b00, g_ref_y = 2'b00, dx, dy;
  int         gate_mode = 0;  // 0 dual_and, 1 silent, 2 toggles both rails

  int n_vec = 0;
  int n_err = 0;

  dual_gate_arbiter_if #(.N_REQ(N)) ifc ();

  dual_gate_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_if      (ifc),
    .gate_x      (gate_x),
    .gate_y      (gate_y),
    .gate_reset  (gate_reset),
    .gate_result (gate_result),
    .busy        (busy),
    .fault_sticky(fault_sticky)
  );

  always #5 clock = ~clock;

  // Gate: fires once both inputs have seen a rail transition since its last firing.
  always @(gate_x or gate_y or gate_reset or gate_mode) begin
    dx = gate_x ^ g_ref_x;
    dy = gate_y ^ g_ref_y;
    if (gate_reset) begin
      gate_result = 2'b00;
      g_ref_x     = gate_x;
      g_ref_y     = gate_y;
    end else if (dx != 2'b00 && dy != 2'b00) begin
      if (gate_mode == 0) gate_result = gate_result ^ ((dx[1] && dy[1]) ? 2'b10 : 2'b01);
      else if (gate_mode == 2) gate_result = gate_result ^ 2'b11;
      g_ref_x = gate_x;
      g_ref_y = gate_y;
    end
  end

  // Reference timeline: cycle 0 is the cycle in which reset_n is released.
  int         cyc = 0;
  int         m_idle_from = SYNC + RSTC;
  int         m_init_start = 0;
  int         m_rr = 0;
  int         m_resp_cyc = -1;
  int         m_resp_idx = 0;
  int         m_sticky_from = 32'h7fff_ffff;
  logic       m_resp_data = 1'b0, m_resp_err = 1'b0;
  logic [1:0] m_gx = 2'b00, m_gy = 2'b00;

  function automatic logic [3:0] exp_grant();
    if (!reset_n || cyc < m_idle_from) return 4'b0000;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (ifc.req_valid[j]) return 4'(1 << j);
    end
    return 4'b0000;
  endfunction

  always @(posedge clock or negedge reset_n) begin : model
    logic [3:0] g;
    int         idx, r;
    logic       xb, yb;
    if (!reset_n) begin
      cyc = 0; m_idle_from = SYNC + RSTC; m_init_start = 0; m_rr = 0;
      m_resp_cyc = -1; m_sticky_from = 32'h7fff_ffff; m_gx = 2'b00; m_gy = 2'b00;
    end else begin
      g = exp_grant();
      if (g != 4'b0000) begin
        idx = 0;
        for (int k = 0; k < N; k++) if (g[k]) idx = k;
        xb = ifc.req_x[idx];
        yb = ifc.req_y[idx];
        if (xb) m_gx[1] = ~m_gx[1]; else m_gx[0] = ~m_gx[0];
        if (yb) m_gy[1] = ~m_gy[1]; else m_gy[0] = ~m_gy[0];
        m_rr       = (idx + 1) % N;
        m_resp_idx = idx;
        r          = (gate_mode == 1) ? cyc + TIMEOUT + 1 : cyc + SYNC + 2;
        m_resp_cyc = r;
        m_resp_err = (gate_mode != 0);
        m_resp_data = (gate_mode == 0) ? (xb & yb) : 1'b0;
        if (m_resp_err) begin
          m_init_start  = r + 1;
          m_idle_from   = r + 1 + RSTC + SYNC;
          if (r + 1 < m_sticky_from) m_sticky_from = r + 1;
        end else begin
          m_idle_from = r;
        end
      end
      cyc++;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  always @(negedge clock) begin : compare
    logic [3:0] erv;
    erv = (reset_n && cyc == m_resp_cyc) ? 4'(1 << m_resp_idx) : 4'b0000;
    cmp("req_ready", 32'(ifc.req_ready), 32'(exp_grant()));
    cmp("resp_valid", 32'(ifc.resp_valid), 32'(erv));
    if (erv != 4'b0000) begin
      cmp("resp_data", 32'(ifc.resp_data), 32'(m_resp_data));
      cmp("resp_error", 32'(ifc.resp_error), 32'(m_resp_err));
    end
    cmp("gate_x", 32'(gate_x), 32'(m_gx));
    cmp("gate_y", 32'(gate_y), 32'(m_gy));
    cmp("gate_reset", 32'(gate_reset),
        32'(reset_n == 1'b0 || (cyc >= m_init_start && cyc < m_init_start + RSTC)));
    cmp("busy", 32'(busy), 32'(!reset_n || cyc < m_idle_from));
    cmp("fault_sticky", 32'(fault_sticky), 32'(reset_n && cyc >= m_sticky_from));
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Present one request, hold it until granted, then report cycles from handshake to response.
  task automatic do_req(input int idx, input logic x, input logic y,
                        output int lat, output logic data, output logic err);
    bit got;
    step();
    ifc.req_valid[idx] = 1'b1;
    ifc.req_x[idx]     = x;
    ifc.req_y[idx]     = y;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clock);
      if (ifc.req_ready[idx]) got = 1;
    end
    cmp("grant_wait", 32'(got), 32'd1);
    step();
    ifc.req_valid[idx] = 1'b0;
    got = 0; lat = 0; data = 1'b0; err = 1'b0;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(negedge clock);
      if (ifc.resp_valid[idx]) begin
        got = 1; lat = k; data = ifc.resp_data; err = ifc.resp_error;
      end
    end
    cmp("resp_wait", 32'(got), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         lat, ngr;
    logic       d, e;
    bit         got;
    logic [3:0] g;
    logic [3:0] order [5];
    logic [3:0] exp_order [5];
    exp_order = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    ifc.req_valid = '0; ifc.req_x = '0; ifc.req_y = '0;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;

    // INIT sequencing after reset
    @(negedge clock);
    cmp("init_grst_c0", 32'(gate_reset), 32'd1);
    cmp("init_busy_c0", 32'(busy), 32'd1);
    @(negedge clock);
    @(negedge clock);
    cmp("init_grst_c2", 32'(gate_reset), 32'd0);
    @(negedge clock);
    cmp("init_busy_c3", 32'(busy), 32'd1);
    @(negedge clock);
    cmp("idle_busy_c4", 32'(busy), 32'd0);
    cmp("idle_ready", 32'(ifc.req_ready), 32'd0);
    cmp("idle_gx", 32'(gate_x), 32'd0);

    // Requester 1, x=1 y=1
    do_req(1, 1'b1, 1'b1, lat, d, e);
    cmp("r1_lat", 32'(lat), 32'd4);
    cmp("r1_data", 32'(d), 32'd1);
    cmp("r1_err", 32'(e), 32'd0);
    cmp("r1_gx", 32'(gate_x), 32'h2);
    cmp("r1_gy", 32'(gate_y), 32'h2);

    // Requester 0, x=1 y=0
    do_req(0, 1'b1, 1'b0, lat, d, e);
    cmp("r0_lat", 32'(lat), 32'd4);
    cmp("r0_data", 32'(d), 32'd0);
    cmp("r0_gx", 32'(gate_x), 32'h0);
    cmp("r0_gy", 32'(gate_y), 32'h3);

    // All four valid continuously; pointer now sits at 1
    step();
    ifc.req_x = 4'b1010; ifc.req_y = 4'b0110; ifc.req_valid = 4'hF;
    ngr = 0;
    for (int k = 0; k < 100 && ngr < 5; k++) begin
      @(negedge clock);
      g = ifc.req_valid & ifc.req_ready;
      if (g != 4'b0000) begin
        order[ngr] = g;
        ngr++;
      end
    end
    step();
    ifc.req_valid = '0;
    cmp("rr_count", 32'(ngr), 32'd5);
    for (int k = 0; k < 5; k++) cmp("rr_order", 32'(order[k]), 32'(exp_order[k]));
    repeat (6) step();

    // Silent gate: timeout fault, then a normal transaction
    gate_mode = 1;
    do_req(2, 1'b1, 1'b1, lat, d, e);
    cmp("to_lat", 32'(lat), 32'(TIMEOUT + 1));
    cmp("to_err", 32'(e), 32'd1);
    cmp("to_data", 32'(d), 32'd0);
    @(negedge clock);
    cmp("to_sticky", 32'(fault_sticky), 32'd1);
    gate_mode = 0;
    do_req(3, 1'b1, 1'b1, lat, d, e);
    cmp("post_to_lat", 32'(lat), 32'd4);
    cmp("post_to_data", 32'(d), 32'd1);
    cmp("post_to_err", 32'(e), 32'd0);

    // Both result rails toggle at once
    gate_mode = 2;
    do_req(0, 1'b1, 1'b1, lat, d, e);
    cmp("dbl_lat", 32'(lat), 32'd4);
    cmp("dbl_err", 32'(e), 32'd1);
    cmp("dbl_data", 32'(d), 32'd0);
    gate_mode = 0;

    // Reset asserted mid-WAIT
    step();
    ifc.req_valid[1] = 1'b1; ifc.req_x[1] = 1'b1; ifc.req_y[1] = 1'b1;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clock);
      if (ifc.req_ready[1]) got = 1;
    end
    cmp("mid_grant_wait", 32'(got), 32'd1);
    step();
    ifc.req_valid[1] = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    cmp("rst_gx", 32'(gate_x), 32'd0);
    cmp("rst_gy", 32'(gate_y), 32'd0);
    cmp("rst_grst", 32'(gate_reset), 32'd1);
    cmp("rst_busy", 32'(busy), 32'd1);
    cmp("rst_sticky", 32'(fault_sticky), 32'd0);
    cmp("rst_resp", 32'(ifc.resp_valid), 32'd0);
    repeat (3) step();
    reset_n = 1'b1;

    // Pointer restarts at 0; requester 2 alone, x=0 y=1
    do_req(2, 1'b0, 1'b1, lat, d, e);
    cmp("after_rst_lat", 32'(lat), 32'd4);
    cmp("after_rst_data", 32'(d), 32'd0);
    cmp("after_rst_gx", 32'(gate_x), 32'h1);
    cmp("after_rst_gy", 32'(gate_y), 32'h2);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
